// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage in front of singlecycle_control and the datapath decoder.
//   It owns the PC. It fetches one instruction word over a req/ack handshake
//   whose latency varies, and it holds that word stable while the core
//   executes it. When the controller commits, the PC moves to the next_pc
//   value that the datapath computed.
//
// Parameters
//   RESET_PC         PC value loaded on reset
//   INSTRET_W        width of the retired-instruction counter
//
// Ports
//   clock            single clock; all state changes on its rising edge
//   reset            asynchronous, active-high
//   imem_req         fetch request; stays high until imem_ack
//   imem_addr        fetch address (always equal to pc)
//   imem_ack         imem_rdata is valid this cycle; ignored when imem_req=0
//   imem_rdata       instruction word from instruction memory
//   next_pc          next PC from the datapath
//   pc_write_enable  controller commit; acted on only while inst_valid=1
//   pc               address of the instruction presented on inst
//   inst             current instruction, or NOP when inst_valid=0
//   inst_opcode      inst[6:0]
//   inst_valid       inst is the word fetched from pc
//   fetch_misaligned sticky flag: a commit targeted a non-word-aligned PC
//   instret          count of committed instructions; wraps silently
//
// State table
//   state | meaning
//   BOOT  | first cycle after reset; no request outstanding
//   FETCH | request for pc outstanding, waiting for imem_ack
//   HOLD  | instruction presented, waiting for the controller commit
//   ERROR | a commit targeted a misaligned PC; parked until reset

module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  input  logic [31:0]          next_pc,
  input  logic                 pc_write_enable,
  output logic [31:0]          pc,
  output logic [31:0]          inst,
  output logic [6:0]           inst_opcode,
  output logic                 inst_valid,
  output logic                 fetch_misaligned,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            inst_q, inst_d;
  logic                   misaligned_q, misaligned_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      misaligned_q <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      misaligned_q <= misaligned_d;
      instret_q    <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    misaligned_d = misaligned_q;
    instret_d    = instret_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        // imem_rdata is sampled only here, so an undriven bus never
        // reaches inst_q.
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (pc_write_enable) begin
          instret_d = instret_q + INSTRET_W'(1);
          pc_d      = next_pc;
          if (next_pc[1:0] == 2'b00) begin
            state_d = FETCH;
          end else begin
            misaligned_d = 1'b1;
            state_d      = ERROR;
          end
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Every output is decoded from registered state, so nothing flows
  // combinationally from an input to an output.
  assign imem_req         = (state_q == FETCH);
  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign inst_valid       = (state_q == HOLD);
  assign inst             = inst_valid ? inst_q : NOP;
  assign inst_opcode      = inst[6:0];
  assign fetch_misaligned = misaligned_q;
  assign instret          = instret_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] next_pc = 32'h0;
  logic        pc_write_enable = 1'b0;

  logic        imem_req, inst_valid, fetch_misaligned;
  logic [31:0] imem_addr, pc, inst, instret;
  logic [6:0]  inst_opcode;

  logic        imem_req4, inst_valid4, fetch_misaligned4;
  logic [31:0] imem_addr4, pc4, inst4;
  logic [6:0]  inst_opcode4;
  logic [3:0]  instret4;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clock = ~clock;

  instruction_fetch #(.RESET_PC(RST_PC), .INSTRET_W(32)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .next_pc(next_pc), .pc_write_enable(pc_write_enable),
    .pc(pc), .inst(inst), .inst_opcode(inst_opcode),
    .inst_valid(inst_valid), .fetch_misaligned(fetch_misaligned),
    .instret(instret)
  );

  // Same stimulus, narrow counter: only instret differs from the main DUT.
  instruction_fetch #(.RESET_PC(RST_PC), .INSTRET_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .imem_req(imem_req4), .imem_addr(imem_addr4),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .next_pc(next_pc), .pc_write_enable(pc_write_enable),
    .pc(pc4), .inst(inst4), .inst_opcode(inst_opcode4),
    .inst_valid(inst_valid4), .fetch_misaligned(fetch_misaligned4),
    .instret(instret4)
  );

  // Reference model: flags describing what the fetch unit is doing.
  logic        m_booting, m_waiting, m_have, m_fault;
  logic [31:0] m_pc, m_inst, m_count;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_booting <= 1'b1;
      m_waiting <= 1'b0;
      m_have    <= 1'b0;
      m_fault   <= 1'b0;
      m_pc      <= RST_PC;
      m_inst    <= NOP;
      m_count   <= 32'd0;
    end else if (m_booting) begin
      m_booting <= 1'b0;
      m_waiting <= 1'b1;
    end else if (m_waiting && imem_ack) begin
      m_waiting <= 1'b0;
      m_have    <= 1'b1;
      m_inst    <= imem_rdata;
    end else if (m_have && pc_write_enable) begin
      m_have  <= 1'b0;
      m_count <= m_count + 32'd1;
      m_pc    <= next_pc;
      if (next_pc % 4 == 0) m_waiting <= 1'b1;
      else                  m_fault   <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      logic [31:0] e_inst;
      e_inst = m_have ? m_inst : NOP;
      check("req",        {31'd0, imem_req},         {31'd0, m_waiting});
      check("addr",       imem_addr,                 m_pc);
      check("pc",         pc,                        m_pc);
      check("valid",      {31'd0, inst_valid},       {31'd0, m_have});
      check("inst",       inst,                      e_inst);
      check("opcode",     {25'd0, inst_opcode},      {25'd0, e_inst[6:0]});
      check("misaligned", {31'd0, fetch_misaligned}, {31'd0, m_fault});
      check("instret",    instret,                   m_count);
      check("instret4",   {28'd0, instret4},         {28'd0, m_count[3:0]});
      check("pc4",        pc4,                       m_pc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    int sel;
    int fault_wait;

    #1 reset = 1'b1;
    cmp_en = 1'b1;
    tick(); tick();
    at_neg();
    check("lit_reset_pc", pc, 32'h0040_0000);
    check("lit_reset_inst", inst, 32'h0000_0013);
    check("lit_reset_req", {31'd0, imem_req}, 32'd0);

    // 1: boot, fetch acked on first cycle
    tick(); reset = 1'b0;
    at_neg();
    check("lit_t1_boot_req", {31'd0, imem_req}, 32'd0);
    tick(); imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    at_neg();
    check("lit_t1_req", {31'd0, imem_req}, 32'd1);
    check("lit_t1_addr", imem_addr, 32'h0040_0000);
    tick(); imem_ack = 1'b0; imem_rdata = 'x;
    at_neg();
    check("lit_t1_valid", {31'd0, inst_valid}, 32'd1);
    check("lit_t1_opcode", {25'd0, inst_opcode}, 32'h13);

    // 3: hold three cycles, then commit to +4
    for (int i = 0; i < 3; i++) begin
      tick();
      at_neg();
      check("lit_t3_inst", inst, 32'h0000_0093);
      check("lit_t3_pc", pc, 32'h0040_0000);
    end
    pc_write_enable = 1'b1; next_pc = 32'h0040_0004;
    tick(); pc_write_enable = 1'b0;
    at_neg();
    check("lit_t3_req", {31'd0, imem_req}, 32'd1);
    check("lit_t3_addr", imem_addr, 32'h0040_0004);
    check("lit_t3_instret", instret, 32'd1);

    // 2: ack held low for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      at_neg();
      check("lit_t2_req", {31'd0, imem_req}, 32'd1);
      check("lit_t2_addr", imem_addr, 32'h0040_0004);
      check("lit_t2_inst", inst, NOP);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0041_0113;
    tick(); imem_ack = 1'b0; imem_rdata = 'x;

    // 4: misaligned commit parks the unit
    pc_write_enable = 1'b1; next_pc = 32'h0040_0102;
    tick();
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i % 2 == 0);
      tick();
    end
    imem_ack = 1'b0; pc_write_enable = 1'b0;
    at_neg();
    check("lit_t4_misaligned", {31'd0, fetch_misaligned}, 32'd1);
    check("lit_t4_req", {31'd0, imem_req}, 32'd0);
    check("lit_t4_pc", pc, 32'h0040_0102);
    reset = 1'b1;
    #1;
    check("lit_t4_clr_mis", {31'd0, fetch_misaligned}, 32'd0);
    check("lit_t4_clr_pc", pc, 32'h0040_0000);
    check("lit_t4_clr_instret", instret, 32'd0);

    // 5: reset mid-fetch, late ack during BOOT ignored
    tick(); reset = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    tick(); reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
    tick(); imem_ack = 1'b0; imem_rdata = 'x;
    at_neg();
    check("lit_t5_req", {31'd0, imem_req}, 32'd1);
    check("lit_t5_addr", imem_addr, 32'h0040_0000);
    check("lit_t5_valid", {31'd0, inst_valid}, 32'd0);

    // 6: 16 zero-wait commits with pc_write_enable tied high
    pc_write_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
      next_pc = RST_PC + 32'(4 * (i + 1));
      tick();
      imem_ack = 1'b0; imem_rdata = 'x;
      tick();
    end
    pc_write_enable = 1'b0;
    at_neg();
    check("lit_t6_instret4", {28'd0, instret4}, 32'd0);
    check("lit_t6_instret", instret, 32'd16);
    check("lit_t6_pc", pc4, 32'h0040_0040);

    // randomized traffic against the model
    fault_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = 1'b0;
      if (m_fault) fault_wait++;
      if (fault_wait > 4 || $urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        fault_wait = 0;
      end
      imem_ack = ($urandom_range(0, 2) == 0);
      imem_rdata = imem_ack ? 32'($urandom) : 'x;
      pc_write_enable = ($urandom_range(0, 1) == 1);
      r = $urandom;
      sel = $urandom_range(0, 99);
      if (sel < 2)       next_pc = r | 32'h1;
      else if (sel < 10) next_pc = r & 32'hffff_fffc;
      else               next_pc = m_pc + 32'd4;
    end
    reset = 1'b0;
    tick(); tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
